// File: rtl/mem_port_arbiter.sv
// Two-master to one-memory port arbiter, round-robin or fixed priority.
// Latency: one arbitration cycle in IDLE, then commands pass combinationally to memory.
// Backpressure: memory stall is forwarded to the owner; the other master is always stalled.
module mem_port_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  m0_addr,
  input  logic [31:0]  m1_addr,
  input  logic [127:0] m0_writedata,
  input  logic [127:0] m1_writedata,
  input  logic         m0_read,
  input  logic         m1_read,
  input  logic         m0_write,
  input  logic         m1_write,
  output logic [127:0] m0_readdata,
  output logic [127:0] m1_readdata,
  output logic         m0_readdata_valid,
  output logic         m1_readdata_valid,
  output logic         m0_waitrequest,
  output logic         m1_waitrequest,
  output logic [31:0]  s_addr,
  output logic [127:0] s_writedata,
  output logic         s_read,
  output logic         s_write,
  input  logic [127:0] s_readdata,
  input  logic         s_readdata_valid,
  input  logic         s_waitrequest,
  output logic         grant,
  output logic [31:0]  cnt_g0,
  output logic [31:0]  cnt_g1
);

  typedef enum logic [1:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD} state_t;

  state_t state, state_nxt;
  logic   grant_nxt;
  logic   grant_ld;
  logic   req0, req1;
  logic   gr_read, gr_write;
  logic   gr_wait;
  logic   gr_rdv;

  assign req0     = m0_read | m0_write;
  assign req1     = m1_read | m1_write;
  assign gr_read  = grant ? m1_read  : m0_read;
  assign gr_write = grant ? m1_write : m0_write;

  // Read data is broadcast; only the valid strobe is steered to the owner.
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

  assign m0_waitrequest    = grant ? 1'b1 : gr_wait;
  assign m1_waitrequest    = grant ? gr_wait : 1'b1;
  assign m0_readdata_valid = ~grant & gr_rdv;
  assign m1_readdata_valid = grant & gr_rdv;

  // Next-state, arbitration decision and memory-side command steering.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    grant_ld    = 1'b0;
    s_addr      = grant ? m1_addr : m0_addr;
    s_writedata = grant ? m1_writedata : m0_writedata;
    s_read      = 1'b0;
    s_write     = 1'b0;
    gr_wait     = 1'b1;
    gr_rdv      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_ld = 1'b1;
          if (req0 && req1) grant_nxt = (RR_EN != 0) ? ~grant : 1'b0;
          else              grant_nxt = req1;
          // Read wins when the winner raises both commands.
          state_nxt = (grant_nxt ? m1_read : m0_read) ? RD_CMD : WR_CMD;
        end
      end
      RD_CMD: begin
        // Only the command that won the grant is forwarded, so a master
        // raising both never issues a read and a write at once.
        s_read  = gr_read;
        gr_wait = s_waitrequest;
        if (!gr_read)            state_nxt = IDLE;
        else if (!s_waitrequest) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        gr_rdv = s_readdata_valid;
        if (s_readdata_valid) state_nxt = IDLE;
      end
      WR_CMD: begin
        s_write = gr_write;
        gr_wait = s_waitrequest;
        if (!gr_write || !s_waitrequest) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, owner and per-master grant counters; reset favours master 0 on the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= 1'b1;
      cnt_g0 <= 32'd0;
      cnt_g1 <= 32'd0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (grant_ld) begin
        if (grant_nxt) cnt_g1 <= cnt_g1 + 32'd1;
        else           cnt_g0 <= cnt_g0 + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized transaction rounds.
// Round-robin instance carries most checks; a fixed-priority instance covers starvation.
// Memory and masters are modelled as transactions with random stalls and read latency.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  m0_addr, m1_addr;
  logic [127:0] m0_writedata, m1_writedata;
  logic         m0_read, m1_read, m0_write, m1_write;
  logic [127:0] s_readdata;
  logic         s_readdata_valid, s_waitrequest;

  logic [127:0] m0_readdata, m1_readdata;
  logic         m0_readdata_valid, m1_readdata_valid, m0_waitrequest, m1_waitrequest;
  logic [31:0]  s_addr;
  logic [127:0] s_writedata;
  logic         s_read, s_write, grant;
  logic [31:0]  cnt_g0, cnt_g1;

  logic [127:0] f_m0_readdata, f_m1_readdata;
  logic         f_m0_readdata_valid, f_m1_readdata_valid, f_m0_waitrequest, f_m1_waitrequest;
  logic [31:0]  f_s_addr;
  logic [127:0] f_s_writedata;
  logic         f_s_read, f_s_write, f_grant;
  logic [31:0]  f_cnt_g0, f_cnt_g1;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_writedata(m0_writedata), .m1_writedata(m1_writedata),
    .m0_read(m0_read), .m1_read(m1_read), .m0_write(m0_write), .m1_write(m1_write),
    .m0_readdata(m0_readdata), .m1_readdata(m1_readdata),
    .m0_readdata_valid(m0_readdata_valid), .m1_readdata_valid(m1_readdata_valid),
    .m0_waitrequest(m0_waitrequest), .m1_waitrequest(m1_waitrequest),
    .s_addr(s_addr), .s_writedata(s_writedata), .s_read(s_read), .s_write(s_write),
    .s_readdata(s_readdata), .s_readdata_valid(s_readdata_valid), .s_waitrequest(s_waitrequest),
    .grant(grant), .cnt_g0(cnt_g0), .cnt_g1(cnt_g1)
  );

  mem_port_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_writedata(m0_writedata), .m1_writedata(m1_writedata),
    .m0_read(m0_read), .m1_read(m1_read), .m0_write(m0_write), .m1_write(m1_write),
    .m0_readdata(f_m0_readdata), .m1_readdata(f_m1_readdata),
    .m0_readdata_valid(f_m0_readdata_valid), .m1_readdata_valid(f_m1_readdata_valid),
    .m0_waitrequest(f_m0_waitrequest), .m1_waitrequest(f_m1_waitrequest),
    .s_addr(f_s_addr), .s_writedata(f_s_writedata), .s_read(f_s_read), .s_write(f_s_write),
    .s_readdata(s_readdata), .s_readdata_valid(s_readdata_valid), .s_waitrequest(s_waitrequest),
    .grant(f_grant), .cnt_g0(f_cnt_g0), .cnt_g1(f_cnt_g1)
  );

  logic [1:0] rdv_v, wr_v;
  assign rdv_v = {m1_readdata_valid, m0_readdata_valid};
  assign wr_v  = {m1_waitrequest, m0_waitrequest};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m0_read = 0; m1_read = 0; m0_write = 0; m1_write = 0;
    s_readdata_valid = 0; s_waitrequest = 0; s_readdata = '0;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // Reference-model state for the randomized rounds
  int           cnt [2];
  int           last, mask, nreq, served, stall, lat, w, rounds_first;
  bit           pend [2];
  bit           rd [2];
  int           order [2];
  logic [31:0]  addr [2];
  logic [127:0] wd [2];
  logic [127:0] rdat;
  logic         cmd;
  int           nrd, m1v, starve;
  logic [127:0] a5_line;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    m0_addr = '0; m1_addr = '0; m0_writedata = '0; m1_writedata = '0;
    do_reset();

    // Reset state
    #1;
    chk("rst_s_read", s_read, 0);
    chk("rst_s_write", s_write, 0);
    chk("rst_wait", wr_v, 2'b11);
    chk("rst_rdv", rdv_v, 2'b00);
    chk("rst_cnt0", cnt_g0, 0);
    chk("rst_cnt1", cnt_g1, 0);
    chk("rst_grant", grant, 1);
    chk("rst_fp_grant", f_grant, 1);

    // Single m0 read, data returned five cycles after the command
    m0_addr = 32'h0000_1230; m0_read = 1; s_waitrequest = 0;
    nrd = 0; m1v = 0;
    #1;
    chk("rd_idle_wait", m0_waitrequest, 1);
    chk("rd_idle_sread", s_read, 0);
    tick();
    #1;
    chk("rd_cmd_sread", s_read, 1);
    chk("rd_cmd_addr", s_addr, 32'h0000_1230);
    chk("rd_cmd_grant", grant, 0);
    chk("rd_cmd_cnt0", cnt_g0, 1);
    chk("rd_cmd_wait", m0_waitrequest, 0);
    nrd += int'(s_read);
    tick();
    m0_read = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      nrd += int'(s_read);
      m1v += int'(m1_readdata_valid);
      chk("rd_wait_nolvalid", m0_readdata_valid, 0);
      tick();
    end
    rdat = {$urandom, $urandom, $urandom, $urandom};
    s_readdata = rdat; s_readdata_valid = 1;
    #1;
    chk("rd_valid0", m0_readdata_valid, 1);
    chk("rd_valid1", m1_readdata_valid, 0);
    chk("rd_data0", m0_readdata, rdat);
    chk("rd_data1", m1_readdata, rdat);
    tick();
    s_readdata_valid = 0;
    #1;
    nrd += int'(s_read);
    m1v += int'(m1_readdata_valid);
    chk("rd_valid_one_cycle", m0_readdata_valid, 0);
    chk("rd_back_idle", wr_v, 2'b11);
    chk("rd_sread_pulses", nrd, 1);
    chk("rd_m1_novalid", m1v, 0);

    // Both masters hold reads: RR alternates, fixed priority starves m1
    do_reset();
    m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
    m0_read = 1; m1_read = 1; s_waitrequest = 0; s_readdata_valid = 1;
    starve = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (f_m1_waitrequest !== 1'b1) starve++;
      if (c % 3 == 1) begin
        chk("rr_grant", grant, ((c / 3) % 2));
        chk("rr_sread", s_read, 1);
        chk("fp_grant", f_grant, 0);
      end
      tick();
    end
    chk("rr_cnt0", cnt_g0, 2);
    chk("rr_cnt1", cnt_g1, 2);
    chk("fp_cnt0", f_cnt_g0, 4);
    chk("fp_cnt1", f_cnt_g1, 0);
    chk("fp_m1_starved", starve, 0);

    // m1 write stalled three cycles, m0 read queued behind it
    do_reset();
    a5_line = {16{8'hA5}};
    m1_addr = 32'h0000_2000; m1_writedata = a5_line; m1_write = 1; s_waitrequest = 1;
    #1;
    chk("wr_idle_wait", m1_waitrequest, 1);
    tick();
    m0_addr = 32'h0000_3000; m0_read = 1;
    for (int c = 0; c < 4; c++) begin
      s_waitrequest = (c < 3);
      #1;
      chk("wr_swrite", s_write, 1);
      chk("wr_addr", s_addr, 32'h0000_2000);
      chk("wr_data", s_writedata, a5_line);
      chk("wr_m1_wait", m1_waitrequest, (c < 3));
      chk("wr_m0_wait", m0_waitrequest, 1);
      tick();
    end
    m1_write = 0;
    #1;
    chk("wr_idle_swrite", s_write, 0);
    chk("wr_idle_waits", wr_v, 2'b11);
    tick();
    #1;
    chk("wr_next_grant", grant, 0);
    chk("wr_next_sread", s_read, 1);
    chk("wr_next_addr", s_addr, 32'h0000_3000);
    chk("wr_cnt0", cnt_g0, 1);
    chk("wr_cnt1", cnt_g1, 1);
    tick();
    m0_read = 0; s_readdata_valid = 1;
    tick();
    s_readdata_valid = 0;

    // Reset in RD_WAIT, late response must be dropped
    do_reset();
    m1_addr = 32'h0000_4440; m1_read = 1;
    tick();
    tick();
    m1_read = 0;
    #1;
    chk("rw_wait", m1_waitrequest, 1);
    chk("rw_sread", s_read, 0);
    rst = 1;
    tick();
    rst = 0;
    s_readdata_valid = 1;
    #1;
    chk("rw_late_rdv", rdv_v, 2'b00);
    chk("rw_cnt0", cnt_g0, 0);
    chk("rw_cnt1", cnt_g1, 0);
    chk("rw_grant", grant, 1);
    tick();
    #1;
    chk("rw_late_rdv2", rdv_v, 2'b00);
    s_readdata_valid = 0;
    m0_addr = 32'h0000_5550; m0_read = 1;
    tick();
    #1;
    chk("rw_next_grant", grant, 0);
    chk("rw_next_sread", s_read, 1);
    chk("rw_next_cnt0", cnt_g0, 1);
    tick();
    m0_read = 0; s_readdata_valid = 1;
    tick();
    s_readdata_valid = 0;

    // Randomized rounds against a transaction-level model (RR instance)
    do_reset();
    last = 1; cnt[0] = 0; cnt[1] = 0;
    for (int r = 0; r < 40; r++) begin
      mask = $urandom_range(1, 3);
      for (int i = 0; i < 2; i++) begin
        pend[i]  = mask[i];
        rd[i]    = bit'($urandom_range(0, 1));
        addr[i]  = $urandom & 32'hFFFF_FFF0;
        wd[i]    = {$urandom, $urandom, $urandom, $urandom};
      end
      m0_addr = addr[0]; m1_addr = addr[1];
      m0_writedata = wd[0]; m1_writedata = wd[1];
      if (mask == 3) begin
        order[0] = 1 - last; order[1] = last; nreq = 2;
      end else begin
        order[0] = (mask == 2) ? 1 : 0; order[1] = order[0]; nreq = 1;
      end
      served = 0; lat = -1; stall = $urandom_range(0, 2); rounds_first = 1;
      for (int c = 0; c < 40 && served < nreq; c++) begin
        m0_read  = pend[0] && rd[0];
        m0_write = pend[0] && !rd[0];
        m1_read  = pend[1] && rd[1];
        m1_write = pend[1] && !rd[1];
        s_waitrequest    = (stall > 0);
        s_readdata_valid = (lat == 0);
        rdat = {$urandom, $urandom, $urandom, $urandom};
        s_readdata = rdat;
        #1;
        w = order[served];
        cmd = s_read | s_write;
        if (lat >= 0) chk("rnd_no_cmd_in_wait", cmd, 0);
        if (cmd) begin
          if (rounds_first == 1) begin
            chk("rnd_one_cycle_arb", c, 1);
            rounds_first = 0;
          end
          chk("rnd_grant", grant, w);
          chk("rnd_addr", s_addr, addr[w]);
          chk("rnd_sread", s_read, rd[w]);
          chk("rnd_own_wait", wr_v[w], (stall > 0));
          if (pend[1 - w]) chk("rnd_other_wait", wr_v[1 - w], 1);
          if (!rd[w]) chk("rnd_wdata", s_writedata, wd[w]);
        end
        if (lat == 0) begin
          chk("rnd_rdv", rdv_v, (2'b01 << w));
          chk("rnd_rdata", (w == 1) ? m1_readdata : m0_readdata, rdat);
        end
        tick();
        if (lat == 0) begin
          served++; lat = -1; cnt[w]++; last = w;
        end else if (lat > 0) begin
          lat--;
        end else if (cmd) begin
          if (stall == 0) begin
            pend[w] = 0;
            stall = $urandom_range(0, 2);
            if (rd[w]) lat = $urandom_range(0, 3);
            else begin
              served++; cnt[w]++; last = w;
            end
          end else begin
            stall--;
          end
        end
      end
      chk("rnd_round_done", served, nreq);
      m0_read = 0; m1_read = 0; m0_write = 0; m1_write = 0;
      s_readdata_valid = 0; s_waitrequest = 0;
      #1;
      chk("rnd_cnt0", cnt_g0, cnt[0]);
      chk("rnd_cnt1", cnt_g1, cnt[1]);
      chk("rnd_last_grant", grant, last);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
